// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving a word-addressed data memory with a
// combinational read port and a synchronous write port.
// Byte-addressed RV32I loads/stores arrive over a valid/ready handshake.
// Sub-word stores are done as read-modify-write. Loads are extracted and
// sign/zero-extended into a registered response.
// Optional feature macro: DMEM_LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned H/HU/W accesses are reported through rsp_err
//   undefined -> misaligned addresses are aligned down and the access proceeds
module dmem_lsu #(
   parameter int XLEN       = 32,
   parameter int DMEM_WORDS = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   output logic            busy,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            dmem_we
);

   typedef enum logic [1:0] {IDLE, EXEC, WRITE, DONE} state_t;

   state_t          state;
   logic            cap_we;
   logic [2:0]      cap_funct3;
   logic [1:0]      cap_off;
   logic [15:0]     cap_wdata_lo;

   logic            funct3_bad;
   logic            out_of_range;
   logic            req_err;
   logic [XLEN-1:0] acc_addr;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] merged_word;

   assign req_ready    = (state == IDLE);
   assign funct3_bad   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                         (req_funct3 == 3'b111);
   assign out_of_range = ({2'b00, req_addr[XLEN-1:2]} >= XLEN'(DMEM_WORDS));

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
   logic misaligned;

   // Classify the incoming request; misaligned halves/words are errors.
   always_comb begin
      acc_addr = req_addr;
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
      req_err = funct3_bad || out_of_range || misaligned;
   end
`else
   // Classify the incoming request; misaligned halves/words are aligned down.
   always_comb begin
      acc_addr = req_addr;
      case (req_funct3[1:0])
         2'b01:   acc_addr[0]   = 1'b0;
         2'b10:   acc_addr[1:0] = 2'b00;
         default: acc_addr      = req_addr;
      endcase
      req_err = funct3_bad || out_of_range;
   end
`endif

   // Pick the addressed byte/half out of the memory word and extend it.
   always_comb begin
      shifted = dmem_rdata >> {cap_off, 3'b000};
      case (cap_funct3)
         3'b000:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b100:  load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   // Build the read-modify-write word for byte and half stores.
   always_comb begin
      merged_word = dmem_rdata;
      if (cap_funct3[1:0] == 2'b00)
         merged_word[{cap_off, 3'b000} +: 8] = cap_wdata_lo[7:0];
      else
         merged_word[{cap_off[1], 4'b0000} +: 16] = cap_wdata_lo;
   end

   // Control FSM; every memory and response output is registered here so
   // dmem_we can only pulse for one cycle and reset kills it at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cap_we       <= 1'b0;
         cap_funct3   <= 3'b000;
         cap_off      <= 2'b00;
         cap_wdata_lo <= '0;
         rsp_valid    <= 1'b0;
         rsp_err      <= 1'b0;
         rsp_rdata    <= '0;
         busy         <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         dmem_we      <= 1'b0;
      end else begin
         dmem_we <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_we       <= req_we;
                  cap_funct3   <= req_funct3;
                  cap_off      <= acc_addr[1:0];
                  cap_wdata_lo <= req_wdata[15:0];
                  busy         <= 1'b1;
                  rsp_rdata    <= '0;
                  if (req_err) begin
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     rsp_err   <= 1'b0;
                     dmem_addr <= {2'b00, acc_addr[XLEN-1:2]};
                     state     <= EXEC;
                     if (req_we && (req_funct3[1:0] == 2'b10)) begin
                        dmem_we    <= 1'b1;
                        dmem_wdata <= req_wdata;
                     end
                  end
               end
            end
            EXEC: begin
               if (cap_we) begin
                  if (cap_funct3[1:0] == 2'b10) begin
                     rsp_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     dmem_wdata <= merged_word;
                     dmem_we    <= 1'b1;
                     state      <= WRITE;
                  end
               end else begin
                  rsp_rdata <= load_data;
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            WRITE: begin
               rsp_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: self-checking bench for dmem_lsu. Drives a table of load and
// store requests against a behavioural data memory, queues the expected
// response of each request and compares it when the response arrives, then
// runs hand-written reset-during-write and ignored-request sequences.
module tb_dmem_lsu;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   typedef struct {
      string       name;
      logic        pre_en;
      logic [31:0] pre_val;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_we;
      logic        chk_mem;
      logic [9:0]  mem_idx;
      logic [31:0] exp_mem;
      int          hold;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_we;

   logic [31:0] mem [0:1023];
   logic        pre_en = 1'b0;
   logic [9:0]  pre_idx = 10'd0;
   logic [31:0] pre_val = 32'h0;
   int unsigned we_total = 0;
   int unsigned we_start = 0;

   int n_cmp = 0;
   int n_fail = 0;

   vec_t vecs[$];
   vec_t sb[$];

   dmem_lsu dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_we    (dmem_we)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, synchronous write, plus a bench preload port.
   assign dmem_rdata = (dmem_addr < 32'd1024) ? mem[dmem_addr[9:0]] : 32'h0;

   always @(posedge clk) begin
      if (pre_en)
         mem[pre_idx] <= pre_val;
      else if (dmem_we && (dmem_addr < 32'd1024))
         mem[dmem_addr[9:0]] <= dmem_wdata;
   end

   // Count every cycle the write enable is seen high at a clock edge.
   always @(posedge clk) begin
      if (dmem_we)
         we_total <= we_total + 1;
   end

   // Hard stop in case anything wedges.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(input string name, input logic pe, input logic [31:0] pv,
                                  input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] er, input logic ee,
                                  input int el, input int ew, input logic cm,
                                  input logic [9:0] mi, input logic [31:0] em, input int hold);
      vec_t v;
      v.name = name; v.pre_en = pe; v.pre_val = pv; v.we = we; v.f3 = f3; v.addr = a;
      v.wdata = wd; v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_we = ew;
      v.chk_mem = cm; v.mem_idx = mi; v.exp_mem = em; v.hold = hold;
      return v;
   endfunction

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic preloadWord(input logic [9:0] idx, input logic [31:0] val);
      pre_en  = 1'b1;
      pre_idx = idx;
      pre_val = val;
      @(posedge clk); #1;
      pre_en  = 1'b0;
   endtask

   // Present one request, queue its expected response, return one cycle after accept.
   task automatic applyStimulus(input vec_t v);
      int waitCnt = 0;
      while (!req_ready && waitCnt < 20) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      checkValue({v.name, ".req_ready_wait"}, req_ready, 1);
      we_start   = we_total;
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      sb.push_back(v);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      checkValue({v.name, ".req_ready_busy"}, req_ready, 0);
      checkValue({v.name, ".busy"}, busy, 1);
   endtask

   // Wait for the response, compare it with the queued expectation, then consume it.
   task automatic checkOutput(input int startLat);
      vec_t v;
      int   lat = startLat;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      if (sb.size() == 0) begin
         n_cmp++; n_fail++;
         $display("[TB] FAIL scoreboard: got response, expected none queued");
         return;
      end
      v = sb.pop_front();
      if (!rsp_valid) begin
         n_cmp++; n_fail++;
         $display("[TB] FAIL %s.timeout: got no rsp_valid within %0d cycles, expected %0d", v.name, lat, v.exp_lat);
         return;
      end
      checkValue({v.name, ".latency"}, lat, v.exp_lat);
      checkValue({v.name, ".rdata"}, rsp_rdata, v.exp_rdata);
      checkValue({v.name, ".err"}, rsp_err, v.exp_err);
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk); #1;
         checkValue({v.name, ".hold_valid"}, rsp_valid, 1);
         checkValue({v.name, ".hold_err"}, rsp_err, v.exp_err);
         checkValue({v.name, ".hold_rdata"}, rsp_rdata, v.exp_rdata);
         checkValue({v.name, ".hold_req_ready"}, req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkValue({v.name, ".valid_drop"}, rsp_valid, 0);
      checkValue({v.name, ".req_ready_next"}, req_ready, 1);
      checkValue({v.name, ".we_cycles"}, we_total - we_start, v.exp_we);
      if (v.chk_mem)
         checkValue({v.name, ".mem"}, mem[v.mem_idx], v.exp_mem);
   endtask

   initial begin
      // Vector table: word 6 lives at byte address 0x18.
      vecs.push_back(mkVec("lw_18",    1, 32'h00001770, 0, F_W,  32'h18, 0, 32'h00001770, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("lb_19",    0, 0,            0, F_B,  32'h19, 0, 32'h00000017, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("lh_18",    0, 0,            0, F_H,  32'h18, 0, 32'h00001770, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("lh_neg",   1, 32'h0000F080, 0, F_H,  32'h18, 0, 32'hFFFFF080, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("lhu_18",   0, 0,            0, F_HU, 32'h18, 0, 32'h0000F080, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("sb_1b",    1, 32'h00001770, 1, F_B,  32'h1B, 32'h000000AB, 0, 0, 3, 1, 1, 10'd6, 32'hAB001770, 0));
      vecs.push_back(mkVec("lb_1b",    0, 0,            0, F_B,  32'h1B, 0, 32'hFFFFFFAB, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("lbu_1b",   0, 0,            0, F_BU, 32'h1B, 0, 32'h000000AB, 0, 2, 0, 0, 0, 0, 0));
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      vecs.push_back(mkVec("lw_1a",    0, 0,            0, F_W,  32'h1A, 0, 32'h00000000, 1, 1, 0, 0, 0, 0, 0));
`else
      vecs.push_back(mkVec("lw_1a",    0, 0,            0, F_W,  32'h1A, 0, 32'hAB001770, 0, 2, 0, 0, 0, 0, 0));
`endif
      vecs.push_back(mkVec("sw_oor",   0, 0,            1, F_W,  32'h1000, 32'hDEADBEEF, 0, 1, 1, 0, 1, 10'd6, 32'hAB001770, 3));
      vecs.push_back(mkVec("sh_1a",    0, 0,            1, F_H,  32'h1A, 32'h1234BEEF, 0, 0, 3, 1, 1, 10'd6, 32'hBEEF1770, 0));
      vecs.push_back(mkVec("sw_18",    0, 0,            1, F_W,  32'h18, 32'hCAFEF00D, 0, 0, 2, 1, 1, 10'd6, 32'hCAFEF00D, 0));
      vecs.push_back(mkVec("lb_18",    0, 0,            0, F_B,  32'h18, 0, 32'h0000000D, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("lb_1a",    0, 0,            0, F_B,  32'h1A, 0, 32'hFFFFFFFE, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("lh_1a",    0, 0,            0, F_H,  32'h1A, 0, 32'hFFFFCAFE, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("lhu_1a",   0, 0,            0, F_HU, 32'h1A, 0, 32'h0000CAFE, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("ill_ld",   0, 0,            0, 3'b011, 32'h18, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("ill_st",   0, 0,            1, 3'b111, 32'h18, 32'h0, 0, 1, 1, 0, 1, 10'd6, 32'hCAFEF00D, 0));
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
      vecs.push_back(mkVec("lh_19",    0, 0,            0, F_H,  32'h19, 0, 32'h00000000, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("sh_1b",    0, 0,            1, F_H,  32'h1B, 32'h00005555, 0, 1, 1, 0, 1, 10'd6, 32'hCAFEF00D, 0));
`else
      vecs.push_back(mkVec("lh_19",    0, 0,            0, F_H,  32'h19, 0, 32'hFFFFF00D, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("sh_1b",    0, 0,            1, F_H,  32'h1B, 32'h00005555, 0, 0, 3, 1, 1, 10'd6, 32'h5555F00D, 0));
`endif
      vecs.push_back(mkVec("sw_top",   0, 0,            1, F_W,  32'hFFC, 32'h11223344, 0, 0, 2, 1, 1, 10'd1023, 32'h11223344, 0));
      vecs.push_back(mkVec("lw_top",   0, 0,            0, F_W,  32'hFFC, 0, 32'h11223344, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("lbu_top",  0, 0,            0, F_BU, 32'hFFF, 0, 32'h00000011, 0, 2, 0, 0, 0, 0, 0));
      vecs.push_back(mkVec("lw_hi",    0, 0,            0, F_W,  32'h80000000, 0, 0, 1, 1, 0, 0, 0, 0, 0));

      // Reset state while rst_n is held low.
      #2;
      checkValue("reset.rsp_valid", rsp_valid, 0);
      checkValue("reset.rsp_err", rsp_err, 0);
      checkValue("reset.rsp_rdata", rsp_rdata, 0);
      checkValue("reset.dmem_we", dmem_we, 0);
      checkValue("reset.dmem_addr", dmem_addr, 0);
      checkValue("reset.dmem_wdata", dmem_wdata, 0);
      checkValue("reset.busy", busy, 0);
      checkValue("reset.req_ready", req_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         if (vecs[i].pre_en)
            preloadWord(10'd6, vecs[i].pre_val);
         applyStimulus(vecs[i]);
         checkOutput(1);
      end

      // Reset asserted during the WRITE cycle of a half store.
      preloadWord(10'd6, 32'h12345678);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = F_H;
      req_addr   = 32'h18;
      req_wdata  = 32'h00007777;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      @(posedge clk); #1;
      checkValue("rst_mid.we_in_write", dmem_we, 1);
      rst_n = 1'b0;
      #1;
      checkValue("rst_mid.we_drop", dmem_we, 0);
      checkValue("rst_mid.rsp_valid", rsp_valid, 0);
      checkValue("rst_mid.busy", busy, 0);
      @(posedge clk); #1;
      checkValue("rst_mid.mem", mem[6], 32'h12345678);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkValue("rst_mid.post_valid", rsp_valid, 0);
      checkValue("rst_mid.post_ready", req_ready, 1);
      checkValue("rst_mid.post_we", dmem_we, 0);

      // A store presented while the LSU is busy with a load must be ignored.
      applyStimulus(mkVec("lw_ign", 0, 0, 0, F_W, 32'h18, 0, 32'h12345678, 0, 2, 0, 1, 10'd6, 32'h12345678, 0));
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = F_W;
      req_addr   = 32'h18;
      req_wdata  = 32'h0;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      checkOutput(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit: the initiator side of the data-memory interface. Sits between the pipeline MEM stage and the word-addressed data memory.
- Accepts byte-addressed RV32I load/store requests over a valid/ready handshake.
- Drives the memory's word address, write data and write-enable. The memory has a combinational read and a synchronous write.
- Sub-word stores are done as read-modify-write. Loads are extracted and sign/zero-extended. A registered response is returned to the pipeline.

Parameters:
- XLEN, 32, data and address width.
- DMEM_WORDS, 1024, number of 32-bit words in data memory; used for the range check.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  MEM stage presents a request.
- req_ready  output  1  LSU can accept; high only in IDLE.
- req_we  input  1  1=store, 0=load.
- req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data; low bytes used for B/H.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  pipeline consumes the response.
- rsp_rdata  output  XLEN  extended load data; 0 for stores.
- rsp_err  output  1  misaligned or out-of-range access.
- busy  output  1  high whenever state != IDLE; used as pipeline stall.
- dmem_addr  output  XLEN  word index = captured addr[XLEN-1:2].
- dmem_wdata  output  XLEN  write data to memory.
- dmem_rdata  input  XLEN  combinational read data from memory.
- dmem_we  output  1  memory write enable.

Behaviour:
- Reset: rst_n low asynchronously forces the following:
  - state=IDLE.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - dmem_we=0, dmem_addr=0, dmem_wdata=0, busy=0.
  - All capture registers cleared.
- Reset mid-operation: any in-flight request is aborted and no write occurs. If dmem_we was high, it drops immediately.
- Accept: a request is accepted when req_valid && req_ready (IDLE only). On accept, we/funct3/addr/wdata are captured into registers.
- Error check at accept:
  - Misaligned if H/HU with addr[0]!=0, or W with addr[1:0]!=0.
  - Out of range if addr[XLEN-1:2] >= DMEM_WORDS.
  - Illegal funct3 (011, 110, 111) is an error.
  - On error: go to DONE with rsp_err=1. Memory is never written.
- FSM states: IDLE, EXEC, WRITE, DONE.
  - IDLE -> EXEC on a legal accept; IDLE -> DONE on an error accept.
  - EXEC: dmem_addr = captured word index.
    - Load: register the extracted byte/half/word from dmem_rdata, selected by addr[1:0].
      - B and H sign-extend; BU and HU zero-extend.
      - Result goes into rsp_rdata, then -> DONE.
    - SW: dmem_we=1, dmem_wdata=wdata -> DONE.
    - SB/SH: register the merged word, i.e. dmem_rdata with the addressed byte lanes replaced by wdata[7:0] or wdata[15:0] -> WRITE.
  - WRITE: dmem_we=1, dmem_wdata=merged word -> DONE.
  - DONE: rsp_valid=1; rsp_rdata and rsp_err held stable. On rsp_ready, go to IDLE; rsp_valid drops the next cycle.
- dmem_we is high for exactly one cycle per legal store and never in any other state.
- Latency from accept edge to rsp_valid: load 2 cycles, SW 2, SB/SH 3, error 1.
- Back-to-back: if rsp_ready is high in DONE, req_ready goes high the next cycle. There are no bubbles beyond this; no request overlaps another.
- If req_valid is high while busy, the request is ignored. The requester must hold it until req_ready.
- RMW is atomic: no other access reaches memory between the EXEC read and the WRITE.

Optional Feature:
- Macro: DMEM_LSU_MISALIGN_TRAP_EN.
- Defined: misaligned accesses raise rsp_err as described above.
- Undefined: the misalignment check is removed.
  - H/HU force addr[0]=0; W forces addr[1:0]=0. The access then proceeds normally.
  - rsp_err is asserted only for out-of-range addresses and illegal funct3.

Test Plan:
- Memory word 6 = 0x00001770; LW addr 0x18 -> rsp_rdata=0x00001770 two cycles after accept, rsp_err=0, dmem_we never high.
- LB addr 0x19 -> 0x00000017; LH addr 0x18 -> 0x00001770; word 6 = 0x0000F080, LH 0x18 -> 0xFFFFF080, LHU -> 0x0000F080.
- SB addr 0x1B, wdata 0x000000AB on word 0x00001770 -> dmem_we high exactly one cycle in WRITE, word becomes 0xAB001770. Then LB 0x1B -> 0xFFFFFFAB and LBU 0x1B -> 0x000000AB.
- LW addr 0x1A with macro defined -> rsp_err=1 one cycle after accept, no write. Without the macro -> reads word 6.
- SW addr 0x1000 (word 1024) -> rsp_err=1 and memory unchanged. Hold rsp_ready=0 for 3 cycles: rsp_valid and rsp_err stay stable and req_ready stays low.
- Assert rst_n=0 during WRITE of an SH -> dmem_we drops immediately, memory unchanged, rsp_valid=0 and state IDLE after release.
